full_adder: RTL and testbench

- Registered full adder with a valid-qualified operand input: computes a + b + cin and presents sum s and carry-out c one clock after the operands are accepted.
- Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> s, c). Wider builds form a ripple-carry adder.
- Leaf arithmetic block used by datapath logic that needs a registered sum and carry.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 21 ++
 rtl/full_adder.sv | 68 ++++++
 tb/tb_full_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder family.
//   ADDER_MAX_WIDTH : widest operand the ripple-carry adder is qualified for.
//   width_ok()      : elaboration-time range check for a requested WIDTH.
package adder_pkg;

    localparam int unsigned ADDER_MAX_WIDTH = 64;

    function automatic bit width_ok(input int unsigned w);
        return (w >= 1) && (w <= ADDER_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One bit slice of the ripple-carry chain. Purely combinational.
//   a, b : operand bits
//   ci   : carry in from the next-lower slice
//   s    : sum bit
//   co   : carry out to the next-higher slice
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    // Propagate term is shared by the sum and the carry.
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry full adder: {c, s} = a + b + cin, one cycle after in_valid.
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active low; clears s, c and out_valid
//   in_valid  : a, b, cin carry a new operand set this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry in
//   s         : registered sum, modulo 2^WIDTH
//   c         : registered carry out (bit WIDTH of the full sum)
//   out_valid : s and c hold a new result this cycle
module full_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             out_valid
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "full_adder: WIDTH must lie in 1..%0d", ADDER_MAX_WIDTH);
    end

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_valid;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_carry[i]),
            .s  (w_sum[i]),
            .co (w_carry[i+1])
        );
    end

    // Result registers only load on accepted operands so they hold across idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_c     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s <= w_sum;
                r_c <= w_carry[WIDTH];
            end
        end
    end

    assign s         = r_s;
    assign c         = r_c;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;

    logic       a1, b1, cin1;
    logic       s1, c1, ov1;

    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] s8;
    logic       c8, ov8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .s         (s1),
        .c         (c1),
        .out_valid (ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .s         (s8),
        .c         (c8),
        .out_valid (ov8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed truth table of the 1-bit full adder, indexed by {a,b,cin}.
    logic exp_s1 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_c1 [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic [8:0] ref_sum;
    logic [2:0] vec;

    initial begin
        // Reset with live operands presented: nothing may leak through.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_s1",  {63'd0, s1},  64'd0);
            check("rst_c1",  {63'd0, c1},  64'd0);
            check("rst_ov1", {63'd0, ov1}, 64'd0);
            check("rst_w8",  {54'd0, ov8, c8, s8}, 64'd0);
        end

        // Exhaustive WIDTH=1, back to back.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            a1 = vec[2]; b1 = vec[1]; cin1 = vec[0];
            tick();
            check($sformatf("exh%0d_s", i),  {63'd0, s1},  {63'd0, exp_s1[i]});
            check($sformatf("exh%0d_c", i),  {63'd0, c1},  {63'd0, exp_c1[i]});
            check($sformatf("exh%0d_ov", i), {63'd0, ov1}, 64'd1);
        end

        // Hold: load 1+1+0, then idle while the operands wander.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        tick();
        check("hold_load", {61'd0, ov1, c1, s1}, 64'b110);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = (i == 1); cin1 = ~cin1;
            tick();
            check($sformatf("hold%0d", i), {61'd0, ov1, c1, s1}, 64'b010);
        end

        // Operand accepted on the same edge as reset is discarded.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
        tick();
        check("midrst", {61'd0, ov1, c1, s1}, 64'b000);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("midrst_after", {61'd0, ov1, c1, s1}, 64'b000);

        // WIDTH=8 boundaries.
        in_valid = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        tick();
        check("w8_ff_00_1", {54'd0, ov8, c8, s8}, {54'd0, 1'b1, 1'b1, 8'h00});
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        check("w8_ff_ff_1", {54'd0, ov8, c8, s8}, {54'd0, 1'b1, 1'b1, 8'hFF});
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick();
        check("w8_00_00_0", {54'd0, ov8, c8, s8}, {54'd0, 1'b1, 1'b0, 8'h00});
        a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b0;
        tick();
        check("w8_5a_a5_0", {54'd0, ov8, c8, s8}, {54'd0, 1'b1, 1'b0, 8'hFF});

        // WIDTH=8 random back-to-back against a 9-bit reference sum.
        for (int i = 0; i < 1000; i++) begin
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            tick();
            check($sformatf("rnd%0d", i), {54'd0, ov8, c8, s8}, {54'd0, 1'b1, ref_sum});
        end

        in_valid = 1'b0;
        tick();
        check("rnd_end_ov", {63'd0, ov8}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
